lcd_screen_arbiter: RTL and testbench
=====================================

# lcd_screen_arbiter

Shares the 2x16 character LCD driver between several requesters, such as lock FSM status, keypad echo and alarm banner. Each requester presents a full screen (two 128-bit rows, 16 ASCII bytes each, MSB byte = leftmost character). The arbiter latches the winning screen onto the driver's `row_1`/`row_2` inputs and holds it for a guaranteed minimum time so that at least one complete LCD refresh frame shows it. With no owner, a default idle screen is passed through.

## Interface
- `NREQ`, 3: number of requesters. Index 0 has the highest priority.
- `HOLD_CYCLES`, 4_000_000: minimum display time in clk cycles. Must be ≥ 1. The default exceeds one driver frame (34 states × 100_000 cycles) at 50 MHz.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  NREQ  level request. Requester i holds `req[i]` high and its rows stable until `grant[i]`.
- `req_row1`  in  NREQ*128  flattened top rows; requester i occupies bits [i*128 +: 128].
- `req_row2`  in  NREQ*128  flattened bottom rows, same packing.
- `idle_row1`, `idle_row2`  in  128 each  default screen shown when there is no owner.
- `row_1`, `row_2`  out  128 each  registered, to the LCD driver.
- `grant`  out  NREQ  one-hot, one-cycle pulse when the requester's rows are latched.
- `done`  out  NREQ  one-hot, one-cycle pulse when ownership ends (expiry or preemption).
- `active`  out  1  high while any requester owns the screen.
- `owner`  out  $clog2(NREQ)  index of the current owner; 0 when `active` is low.

## Operation
- States: ARB, HOLD.
- ARB:
  - `row_1`/`row_2` follow `idle_row1`/`idle_row2`, registered with 1-cycle latency.
  - If any `req` bit is high, the lowest index i wins. Next cycle: rows get requester i's slices, `grant[i]`=1, `owner`=i, `active`=1, hold counter=0, state→HOLD.
- HOLD:
  - Rows are frozen. Requester inputs are ignored except as described below.
  - The counter increments each cycle. At count == HOLD_CYCLES-1: `done[owner]`=1 next cycle, `active`=0, `owner`=0, state→ARB.
- Preemption in HOLD: if `req[j]` is high with j < `owner`, the next cycle carries `done[owner]`=1 and `grant[j]`=1 together. Rows load j's slices, `owner`=j, counter=0, and the state stays in HOLD.
  - Preemption takes precedence over expiry in the same cycle. In that case only one `done`, for the old owner, is issued.
- Equal or lower priority requests wait in HOLD and are never dropped.
- A requester whose `req` is still high when it returns to ARB is re-granted. Requesters must deassert `req` by the cycle after `grant`.
- After expiry, at least one ARB cycle passes before the next grant (idle rows are loaded in that cycle). The exception is the preemption path, which re-grants directly.
- Reset values:
  - `row_1`=`row_2`=128'h20 repeated ×16 (all spaces).
  - `grant`=0, `done`=0, `active`=0, `owner`=0, state=ARB, counter=0.
- Reset mid-HOLD aborts ownership with no `done` pulse.
- The counter is 32 bits wide and never wraps, because it is cleared on every grant and expiry.

## Timing
- `req` seen high in ARB at cycle t → `grant` and new rows at t+1.
- Grant at cycle g → `done` at cycle g+HOLD_CYCLES, unless preempted.
- `idle_row*` change at t → visible on `row_*` at t+1 while in ARB.
- `grant` and `done` are single-cycle pulses and are never asserted for the same index in the same cycle.
- All outputs are registered.

## Structure
- Shared package `lcd_pkg`:
  - `ROW_W`=128.
  - `BLANK_ROW`=128'h20 repeated ×16.
  - State enum {ARB, HOLD}.
  - `LCD_FRAME_CYCLES`=3_400_000, for a bench check that HOLD_CYCLES ≥ frame.
- Sub-module `lcd_prio_enc`: parameterised fixed-priority encoder (NREQ → valid + index), also used for the preemption compare.

## Test plan
- Reset with no requests → rows all 0x20. After 1 cycle the rows track idle_row1="LOCKED" padded with spaces, and `active`=0.
- `req[2]` held for 1 cycle then dropped, HOLD_CYCLES=10 → `grant[2]` at t+1 with rows = slice 2, `done[2]` exactly 10 cycles later, then idle rows return.
- `req[1]` and `req[2]` high in the same cycle → `grant[1]` first. `req[2]` is kept high and is granted 1 cycle after `done[1]`, following one ARB cycle.
- Owner 2 at count 4, `req[0]` raised → next cycle `done[2]`=`grant[0]`=1, rows = slice 0, counter restarts, `done[0]` 10 cycles later.
- `req[0]` raised in the exact cycle that owner 1 expires → single `done[1]` plus `grant[0]`, with no idle cycle in between.
- `rst_n` low mid-HOLD → all outputs at their reset values immediately, with no `done` pulse. After release, normal arbitration resumes.

Source files
------------

// File: rtl/lcd_screen_arbiter_pkg.sv
// Shared types and constants for the LCD screen arbiter slice.
// Row layout: 16 ASCII bytes per row, leftmost character in the top byte.
package lcd_pkg;

    localparam int ROW_W = 128;
    localparam logic [ROW_W-1:0] BLANK_ROW = {16{8'h20}};

    // One full driver refresh frame: 34 states x 100_000 clk cycles.
    localparam int LCD_FRAME_CYCLES = 3_400_000;

    typedef enum logic {
        ARB,
        HOLD
    } arbState_e;

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lcd_screen_arbiter_if.sv
// Requester/driver bundle for the LCD screen arbiter.
// The master side is the requesters plus the LCD driver; the slave side is the arbiter.
interface lcd_screen_arbiter_if #(
    parameter int NREQ = 3
);
    import lcd_pkg::*;

    localparam int OW = idxWidth(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*ROW_W-1:0] req_row1;
    logic [NREQ*ROW_W-1:0] req_row2;
    logic [ROW_W-1:0]      idle_row1;
    logic [ROW_W-1:0]      idle_row2;
    logic [ROW_W-1:0]      row_1;
    logic [ROW_W-1:0]      row_2;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  active;
    logic [OW-1:0]         owner;

    modport master (
        output req, req_row1, req_row2, idle_row1, idle_row2,
        input  row_1, row_2, grant, done, active, owner
    );

    modport slave (
        input  req, req_row1, req_row2, idle_row1, idle_row2,
        output row_1, row_2, grant, done, active, owner
    );

endinterface

// File: rtl/lcd_screen_arbiter_prio_enc.sv
// Fixed-priority encoder: the lowest set request bit wins.
// It serves both fresh arbitration and the preemption check.
module lcd_prio_enc
    import lcd_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]             req_i,
    output logic                     valid_o,
    output logic [idxWidth(N)-1:0]   idx_o
);

    localparam int W = idxWidth(N);

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = W'(i);
            end
        end
    end

endmodule

// File: rtl/lcd_screen_arbiter.sv
// Arbitrates the 2x16 LCD between requesters. A winning screen is frozen on the
// driver rows for HOLD_CYCLES unless a higher-priority requester preempts it.
module lcd_screen_arbiter
    import lcd_pkg::*;
#(
    parameter int NREQ        = 3,
    parameter int HOLD_CYCLES = 4_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lcd_screen_arbiter_if.slave  bus
);

    localparam int OW = idxWidth(NREQ);
    localparam logic [31:0] LAST_COUNT = 32'(HOLD_CYCLES - 1);

    arbState_e         state_q, state_d;
    logic [31:0]       holdCnt_q, holdCnt_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic              active_q, active_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [ROW_W-1:0]  row1_q, row1_d;
    logic [ROW_W-1:0]  row2_q, row2_d;

    logic [NREQ-1:0]   lowerMask;
    logic [NREQ-1:0]   encReq;
    logic              encValid;
    logic [OW-1:0]     encIdx;

    // While holding, only strictly higher-priority requesters reach the encoder.
    always_comb begin
        lowerMask = '0;
        for (int i = 0; i < NREQ; i++) begin
            lowerMask[i] = (i < int'(owner_q));
        end
        encReq = (state_q == HOLD) ? (bus.req & lowerMask) : bus.req;
    end

    lcd_prio_enc #(
        .N (NREQ)
    ) u_prioEnc (
        .req_i   (encReq),
        .valid_o (encValid),
        .idx_o   (encIdx)
    );

    always_comb begin
        state_d   = state_q;
        holdCnt_d = holdCnt_q;
        owner_d   = owner_q;
        active_d  = active_q;
        grant_d   = '0;
        done_d    = '0;
        row1_d    = row1_q;
        row2_d    = row2_q;

        unique case (state_q)
            ARB: begin
                row1_d = bus.idle_row1;
                row2_d = bus.idle_row2;
                if (encValid) begin
                    row1_d          = bus.req_row1[int'(encIdx)*ROW_W +: ROW_W];
                    row2_d          = bus.req_row2[int'(encIdx)*ROW_W +: ROW_W];
                    grant_d[encIdx] = 1'b1;
                    owner_d         = encIdx;
                    active_d        = 1'b1;
                    holdCnt_d       = '0;
                    state_d         = HOLD;
                end
            end
            HOLD: begin
                // Preemption wins over expiry, so only the old owner sees done.
                if (encValid) begin
                    row1_d           = bus.req_row1[int'(encIdx)*ROW_W +: ROW_W];
                    row2_d           = bus.req_row2[int'(encIdx)*ROW_W +: ROW_W];
                    done_d[owner_q]  = 1'b1;
                    grant_d[encIdx]  = 1'b1;
                    owner_d          = encIdx;
                    holdCnt_d        = '0;
                end else if (holdCnt_q == LAST_COUNT) begin
                    done_d[owner_q] = 1'b1;
                    active_d        = 1'b0;
                    owner_d         = '0;
                    holdCnt_d       = '0;
                    state_d         = ARB;
                end else begin
                    holdCnt_d = holdCnt_q + 32'd1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB;
            holdCnt_q <= '0;
            owner_q   <= '0;
            active_q  <= 1'b0;
            grant_q   <= '0;
            done_q    <= '0;
            row1_q    <= BLANK_ROW;
            row2_q    <= BLANK_ROW;
        end else begin
            state_q   <= state_d;
            holdCnt_q <= holdCnt_d;
            owner_q   <= owner_d;
            active_q  <= active_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            row1_q    <= row1_d;
            row2_q    <= row2_d;
        end
    end

    assign bus.row_1  = row1_q;
    assign bus.row_2  = row2_q;
    assign bus.grant  = grant_q;
    assign bus.done   = done_q;
    assign bus.active = active_q;
    assign bus.owner  = owner_q;

endmodule

// File: tb/tb_lcd_screen_arbiter.sv
// Self-checking bench for lcd_screen_arbiter: directed vector table, reset
// sequences, then random requesters against a cycle-level ownership model.
module tb_lcd_screen_arbiter;
    import lcd_pkg::*;

    localparam int NREQ     = 3;
    localparam int HOLD_CYC = 10;

    logic clk;
    logic rst_n;

    lcd_screen_arbiter_if #(.NREQ(NREQ)) bus ();

    lcd_screen_arbiter #(
        .NREQ        (NREQ),
        .HOLD_CYCLES (HOLD_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] req;
        int         n;
        logic [2:0] grant;
        logic [2:0] done;
        logic       active;
        logic [1:0] owner;
        int         rowSel;
    } vec_t;

    vec_t vecs[$];

    logic [127:0] idle1Fix;
    logic [127:0] idle2Fix;

    // Model state: owner index (-1 = none) and cycles the owner has been shown.
    int           mOwner;
    int           mShown;
    logic [127:0] mRow1;
    logic [127:0] mRow2;
    logic [2:0]   mGrant;
    logic [2:0]   mDone;

    function automatic logic [127:0] fixRow(input int line, input int i);
        return {"LINE", 8'h30 + 8'(line), " REQ", 8'h30 + 8'(i), {6{8'h20}}};
    endfunction

    function automatic logic [127:0] expRow(input int line, input int sel);
        if (sel == 3) return (line == 1) ? idle1Fix : idle2Fix;
        return fixRow(line, sel);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic checkVal(input string name, input string field,
                            input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s %s: got %h want %h", name, field, got, want);
        end
    endtask

    task automatic checkOutput(input string name, input logic [2:0] eGrant,
                               input logic [2:0] eDone, input logic eActive,
                               input logic [1:0] eOwner, input logic [127:0] eRow1,
                               input logic [127:0] eRow2);
        checkVal(name, "grant",  128'(bus.grant),  128'(eGrant));
        checkVal(name, "done",   128'(bus.done),   128'(eDone));
        checkVal(name, "active", 128'(bus.active), 128'(eActive));
        checkVal(name, "owner",  128'(bus.owner),  128'(eOwner));
        checkVal(name, "row_1",  bus.row_1, eRow1);
        checkVal(name, "row_2",  bus.row_2, eRow2);
    endtask

    // Called at a falling edge; outputs are examined at the next falling edge.
    task automatic applyStimulus(input logic [2:0] r);
        bus.req = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic resetModel();
        mOwner = -1;
        mShown = 0;
        mRow1  = BLANK_ROW;
        mRow2  = BLANK_ROW;
        mGrant = '0;
        mDone  = '0;
    endtask

    // One clock of the screen-sharing rules, from the inputs seen at that edge.
    task automatic modelStep();
        int win;
        win = -1;
        for (int i = NREQ - 1; i >= 0; i--) if (bus.req[i]) win = i;
        mGrant = '0;
        mDone  = '0;
        if (mOwner < 0) begin
            mRow1 = bus.idle_row1;
            mRow2 = bus.idle_row2;
            if (win >= 0) begin
                mGrant[win] = 1'b1;
                mOwner      = win;
                mShown      = 0;
                mRow1       = bus.req_row1[win*128 +: 128];
                mRow2       = bus.req_row2[win*128 +: 128];
            end
        end else if (win >= 0 && win < mOwner) begin
            mDone[mOwner] = 1'b1;
            mGrant[win]   = 1'b1;
            mOwner        = win;
            mShown        = 0;
            mRow1         = bus.req_row1[win*128 +: 128];
            mRow2         = bus.req_row2[win*128 +: 128];
        end else begin
            mShown++;
            if (mShown == HOLD_CYC) begin
                mDone[mOwner] = 1'b1;
                mOwner        = -1;
            end
        end
    endtask

    initial begin
        logic [2:0] nextReq;

        idle1Fix = {"LOCKED", {10{8'h20}}};
        idle2Fix = {"ENTER CODE", {6{8'h20}}};
        clk           = 1'b0;
        rst_n         = 1'b1;
        bus.req       = '0;
        bus.idle_row1 = idle1Fix;
        bus.idle_row2 = idle2Fix;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_row1[i*128 +: 128] = fixRow(1, i);
            bus.req_row2[i*128 +: 128] = fixRow(2, i);
        end

        //          req     n  grant   done    act   own  rows
        vecs.push_back('{3'b110, 1, 3'b010, 3'b000, 1'b1, 2'd1, 1});
        vecs.push_back('{3'b100, 9, 3'b000, 3'b000, 1'b1, 2'd1, 1});
        vecs.push_back('{3'b100, 1, 3'b000, 3'b010, 1'b0, 2'd0, 1});
        vecs.push_back('{3'b100, 1, 3'b100, 3'b000, 1'b1, 2'd2, 2});
        vecs.push_back('{3'b000, 9, 3'b000, 3'b000, 1'b1, 2'd2, 2});
        vecs.push_back('{3'b000, 1, 3'b000, 3'b100, 1'b0, 2'd0, 2});
        vecs.push_back('{3'b000, 2, 3'b000, 3'b000, 1'b0, 2'd0, 3});
        vecs.push_back('{3'b100, 1, 3'b100, 3'b000, 1'b1, 2'd2, 2});
        vecs.push_back('{3'b000, 4, 3'b000, 3'b000, 1'b1, 2'd2, 2});
        vecs.push_back('{3'b001, 1, 3'b001, 3'b100, 1'b1, 2'd0, 0});
        vecs.push_back('{3'b000, 9, 3'b000, 3'b000, 1'b1, 2'd0, 0});
        vecs.push_back('{3'b000, 1, 3'b000, 3'b001, 1'b0, 2'd0, 0});
        vecs.push_back('{3'b000, 1, 3'b000, 3'b000, 1'b0, 2'd0, 3});
        vecs.push_back('{3'b010, 1, 3'b010, 3'b000, 1'b1, 2'd1, 1});
        vecs.push_back('{3'b000, 9, 3'b000, 3'b000, 1'b1, 2'd1, 1});
        vecs.push_back('{3'b001, 1, 3'b001, 3'b010, 1'b1, 2'd0, 0});
        vecs.push_back('{3'b000, 9, 3'b000, 3'b000, 1'b1, 2'd0, 0});
        vecs.push_back('{3'b000, 1, 3'b000, 3'b001, 1'b0, 2'd0, 0});
        vecs.push_back('{3'b000, 1, 3'b000, 3'b000, 1'b0, 2'd0, 3});

        #1 rst_n = 1'b0;
        #1 checkOutput("reset", 3'b000, 3'b000, 1'b0, 2'd0, BLANK_ROW, BLANK_ROW);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(3'b000);
        checkOutput("idleTrack", 3'b000, 3'b000, 1'b0, 2'd0, idle1Fix, idle2Fix);

        foreach (vecs[v]) begin
            for (int k = 0; k < vecs[v].n; k++) begin
                applyStimulus(vecs[v].req);
                checkOutput($sformatf("vec%0d.%0d", v, k), vecs[v].grant, vecs[v].done,
                            vecs[v].active, vecs[v].owner,
                            expRow(1, vecs[v].rowSel), expRow(2, vecs[v].rowSel));
            end
        end

        $display("[TB] reset during HOLD");
        applyStimulus(3'b010);
        checkOutput("midRstGrant", 3'b010, 3'b000, 1'b1, 2'd1, fixRow(1, 1), fixRow(2, 1));
        for (int k = 0; k < 3; k++) begin
            applyStimulus(3'b000);
            checkOutput("midRstHold", 3'b000, 3'b000, 1'b1, 2'd1, fixRow(1, 1), fixRow(2, 1));
        end
        #2 rst_n = 1'b0;
        #1 checkOutput("midRstAsync", 3'b000, 3'b000, 1'b0, 2'd0, BLANK_ROW, BLANK_ROW);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(3'b000);
            checkOutput("midRstLow", 3'b000, 3'b000, 1'b0, 2'd0, BLANK_ROW, BLANK_ROW);
        end
        rst_n = 1'b1;
        applyStimulus(3'b100);
        checkOutput("postRstGrant", 3'b100, 3'b000, 1'b1, 2'd2, fixRow(1, 2), fixRow(2, 2));
        applyStimulus(3'b000);
        checkOutput("postRstHold", 3'b000, 3'b000, 1'b1, 2'd2, fixRow(1, 2), fixRow(2, 2));

        $display("[TB] random requesters against model");
        rst_n = 1'b0;
        bus.req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        resetModel();
        for (int c = 0; c < 1500; c++) begin
            nextReq = bus.req;
            for (int i = 0; i < NREQ; i++) begin
                if (mGrant[i]) begin
                    nextReq[i] = 1'b0;
                end else if (!nextReq[i] && $urandom_range(0, 5) == 0) begin
                    bus.req_row1[i*128 +: 128] = rnd128();
                    bus.req_row2[i*128 +: 128] = rnd128();
                    nextReq[i] = 1'b1;
                end
            end
            if ($urandom_range(0, 9) == 0) begin
                bus.idle_row1 = rnd128();
                bus.idle_row2 = rnd128();
            end
            applyStimulus(nextReq);
            modelStep();
            checkOutput($sformatf("rand%0d", c), mGrant, mDone, (mOwner >= 0),
                        (mOwner >= 0) ? 2'(mOwner) : 2'd0, mRow1, mRow2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
